// File: rtl/jzjpcc_memory.sv
// Memory-access stage of the jzjpcc pipeline: owns the M and W pipeline registers,
// drives the data RAM port and the 8-word MMIO window, and produces the writeback triple.
module jzjpcc_memory #(
  parameter int RAM_A_WIDTH = 12,
  parameter int PC_MAX_B    = RAM_A_WIDTH + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   memRead_execute,
  input  logic                   memWrite_execute,
  input  logic [2:0]             memFunct3_execute,
  input  logic [31:0]            aluResult_execute,
  input  logic [31:0]            rs2_execute,
  input  logic [4:0]             rdAddr_execute,
  input  logic                   rdWriteEnable_execute,
  output logic [RAM_A_WIDTH-1:0] dataAddress,
  output logic                   dataWriteEnable,
  output logic [3:0]             dataByteEnable,
  output logic [31:0]            dataWriteData,
  input  logic [31:0]            dataReadData,
  input  logic [31:0]            mmioInputs [8],
  output logic [31:0]            mmioOutputs [8],
  output logic [4:0]             rdAddr_memory,
  output logic                   loadInFlight_memory,
  output logic [4:0]             rdAddr_writebackEnd,
  output logic [31:0]            rd_writebackEnd,
  output logic                   rdWriteEnable_writebackEnd
);

  logic        r_memReadM;
  logic        r_memWriteM;
  logic [2:0]  r_funct3M;
  logic [31:0] r_addrM;
  logic [31:0] r_rs2M;
  logic [4:0]  r_rdAddrM;
  logic        r_rdWeM;

  logic        r_memReadW;
  logic        r_isMmioW;
  logic [31:0] r_mmioDataW;
  logic [1:0]  r_offsetW;
  logic [2:0]  r_funct3W;
  logic [31:0] r_aluW;
  logic [4:0]  r_rdAddrW;
  logic        r_rdWeW;

  logic [31:0] r_mmioOut [8];

  logic        w_isMmio;
  logic [2:0]  w_mmioIndex;
  logic [31:0] w_loadWord;
  logic [7:0]  w_loadByte;
  logic [15:0] w_loadHalf;
  logic [31:0] w_loadResult;

  assign w_isMmio    = &r_addrM[31:5];
  assign w_mmioIndex = r_addrM[4:2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_memReadM  <= 1'b0;
      r_memWriteM <= 1'b0;
      r_funct3M   <= 3'b000;
      r_addrM     <= 32'h0;
      r_rs2M      <= 32'h0;
      r_rdAddrM   <= 5'd0;
      r_rdWeM     <= 1'b0;
    end else begin
      r_memReadM  <= memRead_execute;
      r_memWriteM <= memWrite_execute;
      r_funct3M   <= memFunct3_execute;
      r_addrM     <= aluResult_execute;
      r_rs2M      <= rs2_execute;
      r_rdAddrM   <= rdAddr_execute;
      r_rdWeM     <= rdWriteEnable_execute;
    end
  end

  // The async clear also discards a store sitting in M, so it never reaches mmioOutputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_mmioOut[i] <= 32'h0;
    end else if (r_memWriteM && w_isMmio) begin
      r_mmioOut[w_mmioIndex] <= r_rs2M;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_memReadW  <= 1'b0;
      r_isMmioW   <= 1'b0;
      r_mmioDataW <= 32'h0;
      r_offsetW   <= 2'b00;
      r_funct3W   <= 3'b000;
      r_aluW      <= 32'h0;
      r_rdAddrW   <= 5'd0;
      r_rdWeW     <= 1'b0;
    end else begin
      r_memReadW  <= r_memReadM;
      r_isMmioW   <= w_isMmio;
      r_mmioDataW <= mmioInputs[w_mmioIndex];
      r_offsetW   <= r_addrM[1:0];
      r_funct3W   <= r_funct3M;
      r_aluW      <= r_addrM;
      r_rdAddrW   <= r_rdAddrM;
      r_rdWeW     <= r_rdWeM && !r_memWriteM && (r_rdAddrM != 5'd0);
    end
  end

  always_comb begin
    dataWriteEnable = r_memWriteM && !w_isMmio;
    dataByteEnable  = 4'b0000;
    dataWriteData   = r_rs2M;
    case (r_funct3M[1:0])
      2'b00: begin
        dataByteEnable = 4'b0001 << r_addrM[1:0];
        dataWriteData  = {4{r_rs2M[7:0]}};
      end
      2'b01: begin
        dataByteEnable = 4'b0011 << {r_addrM[1], 1'b0};
        dataWriteData  = {2{r_rs2M[15:0]}};
      end
      default: dataByteEnable = 4'b1111;
    endcase
    if (!dataWriteEnable) dataByteEnable = 4'b0000;
  end

  // Sub-word extraction aligns down: bytes use both offset bits, halfwords only bit 1.
  always_comb begin
    w_loadWord = r_isMmioW ? r_mmioDataW : dataReadData;
    case (r_offsetW)
      2'b00:   w_loadByte = w_loadWord[7:0];
      2'b01:   w_loadByte = w_loadWord[15:8];
      2'b10:   w_loadByte = w_loadWord[23:16];
      default: w_loadByte = w_loadWord[31:24];
    endcase
    w_loadHalf = r_offsetW[1] ? w_loadWord[31:16] : w_loadWord[15:0];
    case (r_funct3W)
      3'b000:  w_loadResult = {{24{w_loadByte[7]}}, w_loadByte};
      3'b001:  w_loadResult = {{16{w_loadHalf[15]}}, w_loadHalf};
      3'b100:  w_loadResult = {24'h0, w_loadByte};
      3'b101:  w_loadResult = {16'h0, w_loadHalf};
      default: w_loadResult = w_loadWord;
    endcase
  end

  assign dataAddress                = r_addrM[PC_MAX_B:2];
  assign mmioOutputs                = r_mmioOut;
  assign rdAddr_memory              = r_rdAddrM;
  assign loadInFlight_memory        = r_memReadM;
  assign rdAddr_writebackEnd        = r_rdAddrW;
  assign rd_writebackEnd            = r_memReadW ? w_loadResult : r_aluW;
  assign rdWriteEnable_writebackEnd = r_rdWeW;

endmodule

// File: doc/jzjpcc_memory.md
Name: jzjpcc_memory

Overview:
Memory-access stage of the jzjpcc pipeline, directly downstream of the execute stage. It owns the execute→memory and memory→writeback pipeline registers and performs RV32I loads/stores against the synchronous data RAM port of the memory backend and the 8-word MMIO window. It produces the writeback triple consumed by the register file.

Parameters:
RAM_A_WIDTH, 12, word-address width of data RAM (2^RAM_A_WIDTH words)
PC_MAX_B, RAM_A_WIDTH + 1, MSB of byte address covering RAM; word address is [PC_MAX_B:2]

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
memRead_execute  input  1  instruction in execute is a load
memWrite_execute  input  1  instruction in execute is a store
memFunct3_execute  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
aluResult_execute  input  32  effective address, or ALU result for non-memory ops
rs2_execute  input  32  store data
rdAddr_execute  input  5  destination register
rdWriteEnable_execute  input  1  instruction writes rd
dataAddress  output  RAM_A_WIDTH  word address to RAM ([PC_MAX_B:2] of M-stage address)
dataWriteEnable  output  1  RAM write strobe
dataByteEnable  output  4  per-byte RAM write enables
dataWriteData  output  32  lane-shifted store data
dataReadData  input  32  RAM read data, valid one cycle after dataAddress is presented
mmioInputs  input  32 x 8  memory-mapped inputs
mmioOutputs  output  32 x 8  memory-mapped output registers
rdAddr_memory  output  5  M-stage rd, for hazard/forwarding logic
loadInFlight_memory  output  1  M-stage holds a load, for load-use stall
rdAddr_writebackEnd  output  5  W-stage rd
rd_writebackEnd  output  32  W-stage result
rdWriteEnable_writebackEnd  output  1  W-stage write enable

Behaviour:
- Two register stages.
  - M: latched from the execute inputs at each rising edge.
  - W: latched from M at each rising edge.
- No stall or flush inputs. The stage advances every cycle.
- Address decode on the M-stage address A:
  - MMIO when A[31:5] is all ones (FFFFFFE0–FFFFFFFF); register index is A[4:2].
  - Otherwise RAM at A[PC_MAX_B:2]. Upper bits are ignored, so RAM aliases.
- RAM store, while M holds a store:
  - dataWriteEnable=1.
  - Byte enables follow size and A[1:0]: B → 0001<<A[1:0]; H → 0011<<(A[1]*2); W → 1111.
  - dataWriteData replicates the low byte or halfword across all lanes.
- MMIO store: mmioOutputs[A[4:2]] ← full rs2 at the rising edge that ends M, regardless of size.
- Misalignment: A is aligned down to the access size. No trap and no flag.
- Load path:
  - RAM reads are registered in the memory backend, so dataReadData is valid during W.
  - MMIO read data is sampled from mmioInputs[A[4:2]] into a W register at the M→W edge.
  - W selects the RAM or MMIO source by a registered isMmio bit.
  - W extracts the byte or halfword using the registered A[1:0] (halfword uses A[1]), then sign- or zero-extends per funct3.
  - Reserved load funct3 values (011, 11x) return the full word.
- Non-memory instructions: rd_writebackEnd = registered ALU result.
- rdWriteEnable_writebackEnd is forced 0 when rdAddr is 0. Stores never assert it.
- Load-use latency:
  - A load issued in execute at edge N returns at rd_writebackEnd after edge N+2.
  - loadInFlight_memory=1 for the cycle after edge N+1.
- Register-file write is on the negative edge, so writeback-to-decode needs no forwarding.
- Store in M followed by a load of the same address in the next M: the load sees the new data (RAM write-first or next-cycle ordering is guaranteed by the backend).
- Reset, asynchronous:
  - All M/W registers, mmioOutputs, rdAddr_memory and the writeback outputs go to 0.
  - dataWriteEnable, dataByteEnable and loadInFlight_memory go to 0.
  - A store in M when reset asserts must not be committed.

Test Plan:
- Reset mid-store: assert reset while M holds SW to FFFFFFE4 → mmioOutputs[1] stays 0; all outputs 0 within the same cycle.
- SW 0xDEADBEEF to 0x10, then LW 0x10 → byte enables 1111, dataAddress 4; rd_writebackEnd=DEADBEEF two edges after the LW issues; loadInFlight_memory high for exactly 1 cycle.
- Sub-word stores and loads:
  - SB 0x000000A5 to 0x13 → byteEnable 1000, dataWriteData A5A5A5A5.
  - LB from 0x13 → FFFFFFA5; LBU → 000000A5.
  - LH from 0x12 with word 8001xxxx → FFFF8001; LHU → 00008001.
- MMIO:
  - SW 0x12345678 to FFFFFFFC → mmioOutputs[7]=12345678 after the M→W edge; dataWriteEnable stays 0.
  - mmioInputs[2]=0xCAFE0042 with LW FFFFFFE8 → rd=CAFE0042.
- ALU passthrough with rd=0: ADD result 0x55 to x0 → rdWriteEnable_writebackEnd=0. The same op to x5 → rd=00000055, rdAddr=5, one edge after M.
